pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit: next generation of the combinational fast adder.
//  N-bit operands are split into STAGES equal segments. Each pipeline stage resolves one segment
//  with BLOCK-bit carry-lookahead groups and forwards its carry to the next stage.
//  Valid/ready handshake on both sides; sits between operand-issue logic and the result consumer.
// PARAMETERS
//  N       32  operand/result width; N % STAGES == 0
//  STAGES  4   pipeline register stages = segments = latency; 1..N
//  BLOCK   4   CLA group width inside a segment; (N/STAGES) % BLOCK == 0
// PORTS
//  Clk        in   1  clock, all state on rising edge
//  Rst_n      in   1  asynchronous, active-low reset
//  In_Valid   in   1  operand beat present
//  In_Ready   out  1  unit can accept a beat this cycle
//  Inp1       in   N  operand A
//  Inp2       in   N  operand B
//  Cin        in   1  carry-in (borrow-not for subtract)
//  Sub        in   1  0: A+B+Cin ; 1: A+~B+Cin
//  Out_Valid  out  1  result beat present
//  Out_Ready  in   1  consumer accepts result this cycle
//  Result     out  N  sum/difference
//  Cout       out  1  carry out of bit N-1
//  Ovf        out  1  signed overflow = carry into MSB XOR carry out of MSB
//  Zero       out  1  Result == 0
// BEHAVIOUR
//  - Reset (Rst_n low, async): all stage valid bits, Out_Valid, Result, Cout, Ovf and Zero are
//    cleared to 0. In-flight beats are discarded; no stale beat appears after release.
//  - Advance = !Out_Valid | Out_Ready. In_Ready = Advance; it is combinational and valid during reset=0.
//  - Accept when In_Valid & In_Ready. On Advance, every stage shifts one place. Stage 1 captures the
//    new beat (or a bubble, valid=0). When Advance is 0, the whole pipe holds.
//  - Bubbles are not compressed. Stall is global (one enable) for simplicity and timing.
//  - Sub=1 inverts Inp2 at stage-1 input. Cin is used unchanged, so plain A-B requires Cin=1.
//  - Stage s (1..STAGES) computes segment s-1, bits [(s)*SEG-1:(s-1)*SEG], SEG=N/STAGES:
//    * per-bit g=a&b, p=a^b; group G/P per BLOCK; group carries by lookahead, sum=p^c
//    * carry into segment 0 = Cin. Carry into segment k = registered carry-out of segment k-1.
//    * unresolved operand segments travel in skew registers; resolved sum bits travel forward.
//  - Last stage registers Result, Cout, Ovf and Zero together with Out_Valid.
//  - Latency: beat accepted on edge k is on outputs after edge k+STAGES-1 if no stall.
//    Throughput is 1 beat/cycle.
//  - Outputs hold stable while Out_Valid & !Out_Ready; order is strictly preserved.
//  - Outputs are don't-care (not required 0) while Out_Valid=0, except after reset.
//  - Arithmetic is modulo 2^N; Cout is the unsigned carry (subtract: Cout=1 means no borrow).
//  - STAGES=1 degenerates to a single registered CLA adder with the same handshake.
// TESTING (N=32, STAGES=4, BLOCK=4 unless noted)
//  T1 A=FFFFFFFF B=00000001 Cin=0 Sub=0 -> after edge k+3: Result=0, Cout=1, Ovf=0, Zero=1.
//     This exercises carry across all segments.
//  T2 A=7FFFFFFF B=1 Cin=0 Sub=0 -> 80000000, Cout=0, Ovf=1, Zero=0.
//     A=5 B=7 Cin=1 Sub=1 -> FFFFFFFE, Cout=0, Ovf=0.
//  T3 200 random beats back-to-back, Out_Ready=1 -> Out_Valid first high after edge 3.
//     Then 1 result/cycle, all matching the golden model, in order.
//  T4 Stream with Out_Ready=0 for 3 cycles mid-burst -> In_Ready=0 for those cycles.
//     Result/flags stay stable; no beat lost or duplicated.
//  T5 Sparse input (In_Valid every 3rd cycle) -> bubbles preserved.
//     Each result appears exactly 4 cycles after acceptance.
//  T6 Drop Rst_n for 1 cycle with 3 beats in flight -> Out_Valid=0 immediately (async).
//     No result emerges within 4 cycles after release; rerun T1 with STAGES=1 and STAGES=32.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: each stage resolves one N/STAGES-bit segment with
// BLOCK-bit carry-lookahead groups and hands its registered carry to the next stage.
module pipelined_cla_adder #(
   parameter int N      = 32,
   parameter int STAGES = 4,
   parameter int BLOCK  = 4
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         In_Valid,
   output logic         In_Ready,
   input  logic [N-1:0] Inp1,
   input  logic [N-1:0] Inp2,
   input  logic         Cin,
   input  logic         Sub,
   output logic         Out_Valid,
   input  logic         Out_Ready,
   output logic [N-1:0] Result,
   output logic         Cout,
   output logic         Ovf,
   output logic         Zero
);
   localparam int SEG    = N / STAGES;
   localparam int GROUPS = SEG / BLOCK;

   typedef struct packed {
      logic [SEG-1:0] sum;
      logic           cout;
      logic           cmsb;
   } seg_res_t;

   // Carries inside a group are expanded from the group carry-in; groups chain via G/P.
   function automatic seg_res_t cla_segment(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           c0);
      seg_res_t       r;
      logic [SEG-1:0] g;
      logic [SEG-1:0] p;
      logic [SEG-1:0] c;
      logic           blk_c;
      logic           blk_g;
      logic           blk_p;
      logic           term;
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      blk_c = c0;
      for (int k = 0; k < GROUPS; k++) begin
         for (int i = 0; i < BLOCK; i++) begin
            term = blk_c;
            for (int j = 0; j < i; j++) term = term & p[k*BLOCK+j];
            c[k*BLOCK+i] = term;
            for (int j = 0; j < i; j++) begin
               term = g[k*BLOCK+j];
               for (int m = j + 1; m < i; m++) term = term & p[k*BLOCK+m];
               c[k*BLOCK+i] = c[k*BLOCK+i] | term;
            end
         end
         blk_g = 1'b0;
         blk_p = 1'b1;
         for (int j = 0; j < BLOCK; j++) begin
            term = g[k*BLOCK+j];
            for (int m = j + 1; m < BLOCK; m++) term = term & p[k*BLOCK+m];
            blk_g = blk_g | term;
            blk_p = blk_p & p[k*BLOCK+j];
         end
         blk_c = blk_g | (blk_p & blk_c);
      end
      r.sum  = p ^ c;
      r.cout = blk_c;
      r.cmsb = c[SEG-1];
      return r;
   endfunction

   logic         valid_q [STAGES];
   logic [N-1:0] a_q     [STAGES];
   logic [N-1:0] b_q     [STAGES];
   logic [N-1:0] sum_q   [STAGES];
   logic         carry_q [STAGES];
   logic         ovf_q;
   logic         zero_q;

   logic [N-1:0] a_d     [STAGES];
   logic [N-1:0] b_d     [STAGES];
   logic [N-1:0] sum_d   [STAGES];
   logic         carry_d [STAGES];
   logic         ovf_d;
   logic         zero_d;
   logic         advance;

   assign advance   = !Out_Valid || Out_Ready;
   assign In_Ready  = advance;
   assign Out_Valid = valid_q[STAGES-1];
   assign Result    = sum_q[STAGES-1];
   assign Cout      = carry_q[STAGES-1];
   assign Ovf       = ovf_q;
   assign Zero      = zero_q;

   // Stage s resolves segment s; operands and finished sum bits ride along unchanged.
   always_comb begin
      seg_res_t     seg;
      logic [N-1:0] part;
      a_d[0]     = Inp1;
      b_d[0]     = Sub ? ~Inp2 : Inp2;
      seg        = cla_segment(a_d[0][SEG-1:0], b_d[0][SEG-1:0], Cin);
      part       = '0;
      part[SEG-1:0] = seg.sum;
      sum_d[0]   = part;
      carry_d[0] = seg.cout;
      for (int s = 1; s < STAGES; s++) begin
         a_d[s]     = a_q[s-1];
         b_d[s]     = b_q[s-1];
         seg        = cla_segment(a_q[s-1][s*SEG +: SEG], b_q[s-1][s*SEG +: SEG], carry_q[s-1]);
         part       = sum_q[s-1];
         part[s*SEG +: SEG] = seg.sum;
         sum_d[s]   = part;
         carry_d[s] = seg.cout;
      end
      ovf_d  = seg.cout ^ seg.cmsb;
      zero_d = (sum_d[STAGES-1] == '0);
   end

   // One global enable: the whole pipe shifts together or holds together.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            valid_q[s] <= 1'b0;
            a_q[s]     <= '0;
            b_q[s]     <= '0;
            sum_q[s]   <= '0;
            carry_q[s] <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         valid_q[0] <= In_Valid;
         for (int s = 1; s < STAGES; s++) valid_q[s] <= valid_q[s-1];
         for (int s = 0; s < STAGES; s++) begin
            a_q[s]     <= a_d[s];
            b_q[s]     <= b_d[s];
            sum_q[s]   <= sum_d[s];
            carry_q[s] <= carry_d[s];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed vector table, scoreboard with
// latency tracking, stall/sparse/reset sequences, and STAGES=1/32 carry-chain checks.
module tb_pipelined_cla_adder;
   localparam int N      = 32;
   localparam int STAGES = 4;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         cin;
      logic         sub;
      logic [N-1:0] res;
      logic         cout;
      logic         ovf;
      logic         zero;
   } vec_t;

   typedef struct {
      logic [N-1:0] res;
      logic         cout;
      logic         ovf;
      logic         zero;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] inp1;
   logic [N-1:0] inp2;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   logic         x_valid;
   logic [N-1:0] x_a;
   logic [N-1:0] x_b;
   logic         x_cin;
   logic         x_sub;
   logic         s1_in_ready,  s1_valid,  s1_cout,  s1_ovf,  s1_zero;
   logic         s32_in_ready, s32_valid, s32_cout, s32_ovf, s32_zero;
   logic [N-1:0] s1_result;
   logic [N-1:0] s32_result;

   int   compared   = 0;
   int   mismatched = 0;
   int   step_no    = 0;
   exp_t sb[$];
   vec_t vecs[12];

   always #5 clk = ~clk;

   pipelined_cla_adder #(.N(N), .STAGES(STAGES), .BLOCK(4)) dut (
      .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid), .In_Ready(in_ready),
      .Inp1(inp1), .Inp2(inp2), .Cin(cin), .Sub(sub),
      .Out_Valid(out_valid), .Out_Ready(out_ready), .Result(result),
      .Cout(cout), .Ovf(ovf), .Zero(zero));

   pipelined_cla_adder #(.N(N), .STAGES(1), .BLOCK(4)) dut_s1 (
      .Clk(clk), .Rst_n(rst_n), .In_Valid(x_valid), .In_Ready(s1_in_ready),
      .Inp1(x_a), .Inp2(x_b), .Cin(x_cin), .Sub(x_sub),
      .Out_Valid(s1_valid), .Out_Ready(1'b1), .Result(s1_result),
      .Cout(s1_cout), .Ovf(s1_ovf), .Zero(s1_zero));

   pipelined_cla_adder #(.N(N), .STAGES(32), .BLOCK(1)) dut_s32 (
      .Clk(clk), .Rst_n(rst_n), .In_Valid(x_valid), .In_Ready(s32_in_ready),
      .Inp1(x_a), .Inp2(x_b), .Cin(x_cin), .Sub(x_sub),
      .Out_Valid(s32_valid), .Out_Ready(1'b1), .Result(s32_result),
      .Cout(s32_cout), .Ovf(s32_ovf), .Zero(s32_zero));

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, required %0h (step %0d)", name, act, req, step_no);
      end
   endtask

   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic c, input logic s);
      exp_t         m;
      logic [N-1:0] bb;
      logic [N:0]   full;
      bb     = s ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, c};
      m.res  = full[N-1:0];
      m.cout = full[N];
      m.ovf  = (a[N-1] == bb[N-1]) && (full[N-1] != a[N-1]);
      m.zero = (full[N-1:0] == '0);
      m.due  = -1;
      return m;
   endfunction

   // One cycle: drive at the falling edge, then check what the last rising edge produced.
   task automatic applyStimulus(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic c, input logic s, input logic ordy,
                                input exp_t e, input bit lat, output bit acc);
      @(negedge clk);
      step_no++;
      in_valid  = v;
      inp1      = a;
      inp2      = b;
      cin       = c;
      sub       = s;
      out_ready = ordy;
      #1;
      checkOutput("in_ready", in_ready, !out_valid || ordy);
      if (out_valid) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL spurious_beat: got result %0h, required no beat", result);
         end else begin
            checkOutput("result", result, sb[0].res);
            checkOutput("cout", cout, sb[0].cout);
            checkOutput("ovf", ovf, sb[0].ovf);
            checkOutput("zero", zero, sb[0].zero);
            if (sb[0].due >= 0) begin
               checkOutput("latency", step_no, sb[0].due);
               sb[0].due = -1;
            end
            if (ordy) void'(sb.pop_front());
         end
      end
      acc = v && in_ready;
      if (acc) begin
         e.due = lat ? step_no + STAGES : -1;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input logic ordy);
      exp_t dummy;
      bit   acc;
      dummy = model('0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, ordy, dummy, 1'b0, acc);
   endtask

   task automatic sendVec(input vec_t vv, input logic ordy, input bit lat);
      exp_t e;
      bit   acc;
      e.res  = vv.res;
      e.cout = vv.cout;
      e.ovf  = vv.ovf;
      e.zero = vv.zero;
      e.due  = -1;
      applyStimulus(1'b1, vv.a, vv.b, vv.cin, vv.sub, ordy, e, lat, acc);
      checkOutput("send_accepted", acc, 1'b1);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         idle(1'b1);
         n++;
      end
      checkOutput("drain_empty", sb.size(), 0);
   endtask

   initial begin
      bit   acc;
      bit   pend;
      exp_t e;
      logic [N-1:0] ra, rb;
      logic rc, rs;
      int   lat1, lat32;

      vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; inp1 = '0; inp2 = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1; x_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;
      #1;
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_result", result, '0);
      checkOutput("reset_flags", {cout, ovf, zero}, 3'b000);
      checkOutput("reset_in_ready", in_ready, 1'b1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] directed vector table");
      for (int i = 0; i < 12; i++) sendVec(vecs[i], 1'b1, 1'b1);
      drain(20);

      $display("[TB] back-to-back random stream");
      for (int i = 0; i < 200; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         applyStimulus(1'b1, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs), 1'b1, acc);
         checkOutput("stream_accept", acc, 1'b1);
      end
      drain(20);

      $display("[TB] output stall mid-burst");
      pend = 1'b0;
      ra = '0; rb = '0; rc = 1'b0; rs = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!pend) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            pend = 1'b1;
         end
         applyStimulus(1'b1, ra, rb, rc, rs, !(i >= 6 && i < 9), model(ra, rb, rc, rs), 1'b0, acc);
         if (i >= 6 && i < 9) checkOutput("stall_in_ready", in_ready, 1'b0);
         if (acc) pend = 1'b0;
      end
      drain(20);

      $display("[TB] sparse input with bubbles");
      for (int i = 0; i < 15; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         applyStimulus(i % 3 == 0, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs), 1'b1, acc);
      end
      drain(20);

      $display("[TB] asynchronous reset with beats in flight");
      for (int i = 0; i < 4; i++) sendVec(vecs[4], 1'b0, 1'b0);
      idle(1'b0);
      checkOutput("pre_reset_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_valid", out_valid, 1'b0);
      checkOutput("async_reset_result", result, '0);
      checkOutput("async_reset_flags", {cout, ovf, zero}, 3'b000);
      checkOutput("async_reset_in_ready", in_ready, 1'b1);
      sb.delete();
      in_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < STAGES + 2; i++) begin
         idle(1'b1);
         checkOutput("post_reset_valid", out_valid, 1'b0);
      end

      $display("[TB] carry chain with STAGES=1 and STAGES=32");
      lat1 = -1;
      lat32 = -1;
      @(negedge clk);
      x_valid = 1'b1; x_a = 32'hFFFFFFFF; x_b = 32'h00000001; x_cin = 1'b0; x_sub = 1'b0;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         x_valid = 1'b0;
         #1;
         if (t == 1) checkOutput("s32_in_ready", s32_in_ready, 1'b1);
         if (s1_valid && lat1 < 0) begin
            lat1 = t;
            checkOutput("s1_in_ready", s1_in_ready, 1'b1);
            checkOutput("s1_result", s1_result, '0);
            checkOutput("s1_flags", {s1_cout, s1_ovf, s1_zero}, 3'b101);
         end
         if (s32_valid && lat32 < 0) begin
            lat32 = t;
            checkOutput("s32_result", s32_result, '0);
            checkOutput("s32_flags", {s32_cout, s32_ovf, s32_zero}, 3'b101);
         end
      end
      checkOutput("s1_latency", lat1, 1);
      checkOutput("s32_latency", lat32, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached at step %0d", step_no);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
